controle_imediato: RTL and testbench
====================================

Name: controle_imediato

Overview:
- Multicycle control FSM for I-type instructions (addi, addiu, slti, andi, ori, lui, lw, sw, beq, bne).
- The main control unit hands over after fetch/decode.
- Sequences the 16->32 immediate extender mode, ALU source/op, memory strobes, register writeback and the conditional PC write, then returns control with a one-cycle done.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles spent waiting for mem_ready in a memory state before aborting.

Ports:
- clk  in  1  system clock; every register updates on its rising edge.
- reset  in  1  synchronous, active-high; returns the FSM to IDLE and all outputs to reset values.
- start  in  1  request from main control; sampled only in IDLE.
- opcode  in  6  instruction[31:26]; latched when start is accepted.
- alu_zero  in  1  ALU zero flag, combinational from the current ALU inputs.
- alu_overflow  in  1  ALU signed-overflow flag.
- mem_ready  in  1  memory has completed the current read/write this cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; instruction retired.
- ext_mode  out  2  extender select: SIGN=00, ZERO=01, LUI=10 (imm<<16).
- alu_src_b  out  1  0 = register B, 1 = extended immediate.
- alu_op  out  3  NOP=000, ADD=001, SUB=010, AND=011, OR=100, SLT=101, PASS_B=110.
- reg_write  out  1  write rt this cycle.
- mem_to_reg  out  1  writeback source is the memory data register.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- pc_write_cond  out  1  load branch target into PC this cycle.
- illegal_op  out  1  one-cycle pulse; unsupported opcode.
- overflow_exc  out  1  one-cycle pulse; addi overflow, writeback suppressed.
- mem_error  out  1  one-cycle pulse; memory timeout.

Behaviour:
Reset and outputs:
- While reset=1 at a clock edge: state=IDLE, wait counter=0, latched opcode=0. All 1-bit outputs are 0, alu_op=NOP, ext_mode=SIGN.
- Outputs are Moore-style from state and latched opcode. Exception: pc_write_cond and overflow_exc also depend on alu_zero and alu_overflow in EXEC.

States: IDLE, EXEC, MEM, WB, DONE, ERR.

IDLE:
- start=1 latches opcode.
- Legal opcode -> EXEC. Otherwise -> ERR.
- start while busy is ignored; there is no queueing.

ERR:
- illegal_op=1 for one cycle, then IDLE. No done.

ext_mode (held constant from EXEC through DONE for the latched opcode):
- ZERO for andi and ori.
- LUI for lui.
- SIGN for all others.

EXEC:
- alu_src_b=1, except beq/bne where alu_src_b=0.
- alu_op:
  - addi/addiu/lw/sw: ADD
  - slti: SLT
  - andi: AND
  - ori: OR
  - lui: PASS_B
  - beq/bne: SUB
- Next state:
  - Arithmetic/logic ops -> WB.
  - addi with alu_overflow=1: overflow_exc=1 this cycle, next state IDLE. No writeback, no done. addiu ignores overflow.
  - lw/sw -> MEM.
  - beq: pc_write_cond = alu_zero. bne: pc_write_cond = !alu_zero. Both -> DONE.

MEM:
- mem_read=1 (lw) or mem_write=1 (sw) every cycle in this state.
- Counter counts cycles spent in MEM, starting at 1.
- mem_ready=1: lw -> WB, sw -> DONE.
- Counter reaches MEM_TIMEOUT without mem_ready: mem_error=1 for one cycle, strobes drop, next state IDLE, no done.
- If mem_ready arrives in the same cycle as the timeout, mem_ready wins.

WB:
- reg_write=1 for exactly one cycle.
- mem_to_reg=1 for lw, 0 otherwise. Next state DONE.

DONE:
- done=1 for one cycle, then IDLE.
- A new start is accepted in the following IDLE cycle; there is at least one idle cycle between instructions.

Latency from the start-accept edge to done high:
- ALU ops: 3 cycles.
- Branch: 2 cycles.
- sw: 3 + (cycles waited for mem_ready).
- lw: 4 + (cycles waited for mem_ready).

Reset mid-operation:
- Immediate return to IDLE; any pending reg_write/mem strobe is dropped in that same cycle.

Decomposition:
- Package controle_pkg holds:
  - typedef enum for state;
  - typedef enum for ext_mode;
  - typedef enum for alu_op;
  - localparams for the ten opcodes (ADDI 6'h08, ADDIU 6'h09, SLTI 6'h0A, ANDI 6'h0C, ORI 6'h0D, LUI 6'h0F, LW 6'h23, SW 6'h2B, BEQ 6'h04, BNE 6'h05).
- One sub-module, decod_imediato: purely combinational opcode -> {legal, ext_mode, alu_op, alu_src_b, class}. The FSM instantiates it on the latched opcode.

Test Plan:
- ori: start with opcode 0x0D -> ext_mode=ZERO and alu_op=OR in EXEC; reg_write=1, mem_to_reg=0 in WB; done 3 cycles after start; busy high 3 cycles.
- lw with mem_ready delayed 2 cycles: opcode 0x23 -> ext_mode=SIGN, alu_op=ADD; mem_read high for 3 cycles; WB with mem_to_reg=1; done at cycle 6.
- beq and bne, each run with alu_zero=1 and with alu_zero=0 (opcodes 0x04 and 0x05):
  - beq: pc_write_cond = 1 / 0 for alu_zero = 1 / 0.
  - bne: pc_write_cond = 0 / 1 for alu_zero = 1 / 0.
  - In all four runs, pc_write_cond pulses in EXEC only; done 2 cycles after start; reg_write never asserted.
- addi with alu_overflow=1 in EXEC -> overflow_exc pulses one cycle, reg_write stays 0, no done. Repeat with addiu -> normal writeback and done.
- sw with mem_ready held 0 -> mem_write high 15 cycles, mem_error pulse, FSM back in IDLE. Opcode 0x3F -> illegal_op pulse one cycle after start, no done.
- reset asserted in MEM of lw -> next cycle busy=0, mem_read=0, no reg_write, no done. A following start is accepted normally.

Source files
------------

// File: rtl/controle_pkg.sv
// Shared types and opcode constants for the I-type multicycle control slice.
package controle_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1,
        ST_MEM  = 3'd2,
        ST_WB   = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        EXT_SIGN = 2'b00,
        EXT_ZERO = 2'b01,
        EXT_LUI  = 2'b10
    } ext_mode_t;

    typedef enum logic [2:0] {
        ALU_NOP    = 3'b000,
        ALU_ADD    = 3'b001,
        ALU_SUB    = 3'b010,
        ALU_AND    = 3'b011,
        ALU_OR     = 3'b100,
        ALU_SLT    = 3'b101,
        ALU_PASS_B = 3'b110
    } alu_op_t;

    // How the FSM sequences an instruction after EXEC.
    typedef enum logic [2:0] {
        CLS_ALU   = 3'd0,
        CLS_ADDI  = 3'd1,
        CLS_LOAD  = 3'd2,
        CLS_STORE = 3'd3,
        CLS_BEQ   = 3'd4,
        CLS_BNE   = 3'd5
    } op_class_t;

    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;

    function automatic logic opcode_legal(input logic [5:0] op);
        case (op)
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI,
            OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_BNE: opcode_legal = 1'b1;
            default:                              opcode_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/controle_imediato_decod.sv
// Combinational opcode decoder: extender mode, ALU control and sequencing class.
module decod_imediato
    import controle_pkg::*;
(
    input  logic [5:0] opcode,
    output logic       legal,
    output logic [1:0] ext_mode,
    output logic [2:0] alu_op,
    output logic       alu_src_b,
    output logic [2:0] op_class
);

    ext_mode_t ext;
    alu_op_t   op;
    op_class_t cls;

    always_comb begin
        legal     = 1'b1;
        ext       = EXT_SIGN;
        op        = ALU_ADD;
        alu_src_b = 1'b1;
        cls       = CLS_ALU;
        case (opcode)
            OP_ADDI:  cls = CLS_ADDI;
            OP_ADDIU: cls = CLS_ALU;
            OP_SLTI:  op  = ALU_SLT;
            OP_ANDI: begin
                op  = ALU_AND;
                ext = EXT_ZERO;
            end
            OP_ORI: begin
                op  = ALU_OR;
                ext = EXT_ZERO;
            end
            OP_LUI: begin
                op  = ALU_PASS_B;
                ext = EXT_LUI;
            end
            OP_LW:    cls = CLS_LOAD;
            OP_SW:    cls = CLS_STORE;
            // Branches compare two registers, so the immediate is not on port B.
            OP_BEQ: begin
                op        = ALU_SUB;
                alu_src_b = 1'b0;
                cls       = CLS_BEQ;
            end
            OP_BNE: begin
                op        = ALU_SUB;
                alu_src_b = 1'b0;
                cls       = CLS_BNE;
            end
            default: begin
                legal     = 1'b0;
                op        = ALU_NOP;
                alu_src_b = 1'b0;
            end
        endcase
    end

    assign ext_mode = ext;
    assign alu_op   = op;
    assign op_class = cls;

endmodule

// File: rtl/controle_imediato.sv
// Multicycle control FSM for I-type instructions, entered after fetch/decode
// and handing back with a one-cycle done.
module controle_imediato
    import controle_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] opcode,
    input  logic       alu_zero,
    input  logic       alu_overflow,
    input  logic       mem_ready,
    output logic       busy,
    output logic       done,
    output logic [1:0] ext_mode,
    output logic       alu_src_b,
    output logic [2:0] alu_op,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       mem_read,
    output logic       mem_write,
    output logic       pc_write_cond,
    output logic       illegal_op,
    output logic       overflow_exc,
    output logic       mem_error
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [5:0]    op_q;

    logic       dec_legal;
    logic [1:0] dec_ext;
    logic [2:0] dec_alu;
    logic       dec_src_b;
    logic [2:0] dec_class;
    op_class_t  cls;
    logic       mem_timeout;

    decod_imediato u_decod (
        .opcode    (op_q),
        .legal     (dec_legal),
        .ext_mode  (dec_ext),
        .alu_op    (dec_alu),
        .alu_src_b (dec_src_b),
        .op_class  (dec_class)
    );

    assign cls         = op_class_t'(dec_class);
    assign mem_timeout = (wait_cnt == CW'(MEM_TIMEOUT));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            op_q     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q  <= opcode;
                        state <= opcode_legal(opcode) ? ST_EXEC : ST_ERR;
                    end
                end
                ST_EXEC: begin
                    case (cls)
                        CLS_ADDI:            state <= alu_overflow ? ST_IDLE : ST_WB;
                        CLS_LOAD, CLS_STORE: begin
                            state    <= ST_MEM;
                            wait_cnt <= CW'(1);
                        end
                        CLS_BEQ, CLS_BNE:    state <= ST_DONE;
                        default:             state <= ST_WB;
                    endcase
                end
                // A ready in the timeout cycle still completes the access.
                ST_MEM: begin
                    if (mem_ready) begin
                        state    <= (cls == CLS_LOAD) ? ST_WB : ST_DONE;
                        wait_cnt <= '0;
                    end else if (mem_timeout) begin
                        state    <= ST_IDLE;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                ST_WB:   state <= ST_DONE;
                ST_DONE: state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode the registered state and opcode; only the EXEC branch
    // and overflow results look at the live ALU flags.
    always_comb begin
        busy          = (state != ST_IDLE);
        done          = 1'b0;
        ext_mode      = EXT_SIGN;
        alu_src_b     = 1'b0;
        alu_op        = ALU_NOP;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        pc_write_cond = 1'b0;
        illegal_op    = 1'b0;
        overflow_exc  = 1'b0;
        mem_error     = 1'b0;
        case (state)
            ST_EXEC: begin
                ext_mode      = dec_ext;
                alu_src_b     = dec_src_b;
                alu_op        = dec_alu;
                pc_write_cond = ((cls == CLS_BEQ) && alu_zero) ||
                                ((cls == CLS_BNE) && !alu_zero);
                overflow_exc  = (cls == CLS_ADDI) && alu_overflow;
            end
            ST_MEM: begin
                ext_mode  = dec_ext;
                mem_read  = (cls == CLS_LOAD);
                mem_write = (cls == CLS_STORE);
                mem_error = mem_timeout && !mem_ready;
            end
            ST_WB: begin
                ext_mode   = dec_ext;
                reg_write  = 1'b1;
                mem_to_reg = (cls == CLS_LOAD);
            end
            ST_DONE: begin
                ext_mode = dec_ext;
                done     = 1'b1;
            end
            ST_ERR:  illegal_op = !dec_legal;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_controle_imediato.sv
// Randomized bench for controle_imediato: each instruction is expanded into
// its expected per-cycle output trace and compared cycle by cycle.
module tb_controle_imediato;
    import controle_pkg::*;

    localparam int TMO = 15;

    logic       clk, reset, start;
    logic [5:0] opcode;
    logic       alu_zero, alu_overflow, mem_ready;
    logic       busy, done, alu_src_b, reg_write, mem_to_reg;
    logic       mem_read, mem_write, pc_write_cond, illegal_op, overflow_exc, mem_error;
    logic [1:0] ext_mode;
    logic [2:0] alu_op;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] exp_q[$];
    logic        rdy_q[$];

    logic [5:0] legal_ops [10] = '{OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI,
                                   OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_BNE};

    controle_imediato #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode),
        .alu_zero(alu_zero), .alu_overflow(alu_overflow), .mem_ready(mem_ready),
        .busy(busy), .done(done), .ext_mode(ext_mode), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .mem_read(mem_read), .mem_write(mem_write), .pc_write_cond(pc_write_cond),
        .illegal_op(illegal_op), .overflow_exc(overflow_exc), .mem_error(mem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] out_vec();
        return {busy, done, ext_mode, alu_src_b, alu_op, reg_write, mem_to_reg,
                mem_read, mem_write, pc_write_cond, illegal_op, overflow_exc, mem_error};
    endfunction

    function automatic logic [15:0] mk(logic b, logic d, logic [1:0] e, logic s,
                                       logic [2:0] a, logic rw, logic m2r, logic mr,
                                       logic mw, logic pc, logic il, logic ov, logic me);
        return {b, d, e, s, a, rw, m2r, mr, mw, pc, il, ov, me};
    endfunction

    task automatic check_vec(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: expand one instruction into cycles after the start cycle.
    // w = cycles memory stays not-ready before asserting mem_ready.
    task automatic build_expect(input logic [5:0] op, input logic z, input logic v, input int w);
        logic       legal = 1'b0;
        logic [1:0] e;
        logic [2:0] a;
        logic       is_br, is_mem, pc, ov, last;
        int         n;
        foreach (legal_ops[i]) if (legal_ops[i] == op) legal = 1'b1;
        exp_q.delete();
        rdy_q.delete();
        if (!legal) begin
            exp_q.push_back(mk(1,0,2'b00,0,3'b000,0,0,0,0,0,1,0,0));
            rdy_q.push_back(1'($urandom_range(0, 1)));
            return;
        end
        e = (op == OP_ANDI || op == OP_ORI) ? 2'b01 : (op == OP_LUI) ? 2'b10 : 2'b00;
        case (op)
            OP_SLTI:         a = 3'b101;
            OP_ANDI:         a = 3'b011;
            OP_ORI:          a = 3'b100;
            OP_LUI:          a = 3'b110;
            OP_BEQ, OP_BNE:  a = 3'b010;
            default:         a = 3'b001;
        endcase
        is_br  = (op == OP_BEQ) || (op == OP_BNE);
        is_mem = (op == OP_LW) || (op == OP_SW);
        pc = (op == OP_BEQ) ? z : (op == OP_BNE) ? !z : 1'b0;
        ov = (op == OP_ADDI) && v;
        exp_q.push_back(mk(1,0,e,!is_br,a,0,0,0,0,pc,0,ov,0));
        rdy_q.push_back(1'($urandom_range(0, 1)));
        if (ov) return;
        if (is_mem) begin
            n = (w >= TMO) ? TMO : w + 1;
            for (int i = 1; i <= n; i++) begin
                last = (i == n);
                exp_q.push_back(mk(1,0,e,0,3'b000,0,0,op == OP_LW,op == OP_SW,0,0,0,
                                   last && (w >= TMO)));
                rdy_q.push_back(last && (w < TMO));
            end
            if (w >= TMO) return;
        end
        if (!is_br && op != OP_SW) begin
            exp_q.push_back(mk(1,0,e,0,3'b000,1,op == OP_LW,0,0,0,0,0,0));
            rdy_q.push_back(1'($urandom_range(0, 1)));
        end
        exp_q.push_back(mk(1,1,e,0,3'b000,0,0,0,0,0,0,0,0));
        rdy_q.push_back(1'($urandom_range(0, 1)));
    endtask

    // Start cycle, then one check per expected cycle, then one idle cycle.
    task automatic run_instr(input string tag, input logic [5:0] op, input logic z,
                             input logic v, input int w);
        build_expect(op, z, v, w);
        @(negedge clk);
        start = 1'b1; opcode = op; alu_zero = z; alu_overflow = v;
        mem_ready = 1'($urandom_range(0, 1));
        #1 check_vec({tag, "_idle"}, out_vec(), 16'h0);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            start     = 1'($urandom_range(0, 1));
            opcode    = 6'($urandom);
            mem_ready = rdy_q.pop_front();
            #1 check_vec(tag, out_vec(), exp_q.pop_front());
        end
        @(negedge clk);
        start = 1'b0; mem_ready = 1'b0;
        #1 check_vec({tag, "_post"}, out_vec(), 16'h0);
    endtask

    initial begin
        logic [5:0] op;
        reset = 1'b1; start = 1'b1; opcode = OP_ORI;
        alu_zero = 1'b0; alu_overflow = 1'b0; mem_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1 check_vec("reset", out_vec(), 16'h0);
        end
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        #1 check_vec("reset_rel", out_vec(), 16'h0);

        run_instr("ori",        OP_ORI,   0, 0, 0);
        run_instr("lw_w2",      OP_LW,    0, 0, 2);
        run_instr("beq_z1",     OP_BEQ,   1, 0, 0);
        run_instr("beq_z0",     OP_BEQ,   0, 0, 0);
        run_instr("bne_z1",     OP_BNE,   1, 0, 0);
        run_instr("bne_z0",     OP_BNE,   0, 0, 0);
        run_instr("addi_ovf",   OP_ADDI,  0, 1, 0);
        run_instr("addiu_ovf",  OP_ADDIU, 0, 1, 0);
        run_instr("addi",       OP_ADDI,  0, 0, 0);
        run_instr("lui",        OP_LUI,   1, 1, 0);
        run_instr("andi",       OP_ANDI,  0, 0, 0);
        run_instr("slti",       OP_SLTI,  0, 0, 0);
        run_instr("sw_tmo",     OP_SW,    0, 0, 40);
        run_instr("sw_w14",     OP_SW,    0, 0, TMO - 1);
        run_instr("lw_tmo",     OP_LW,    0, 0, TMO);
        run_instr("lw_w0",      OP_LW,    0, 0, 0);
        run_instr("illegal",    6'h3F,    0, 0, 0);

        // Reset while a load waits in MEM.
        build_expect(OP_LW, 0, 0, 5);
        @(negedge clk);
        start = 1'b1; opcode = OP_LW; mem_ready = 1'b0;
        #1 check_vec("rst_mem_idle", out_vec(), 16'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b0; mem_ready = rdy_q.pop_front();
            if (i == 2) reset = 1'b1;
            #1 check_vec("rst_mem_pre", out_vec(), exp_q.pop_front());
        end
        @(negedge clk);
        reset = 1'b0; mem_ready = 1'b1;
        #1 check_vec("rst_mem_after", out_vec(), 16'h0);
        @(negedge clk);
        mem_ready = 1'b0;
        #1 check_vec("rst_mem_idle2", out_vec(), 16'h0);
        run_instr("after_rst",  OP_LW,    0, 0, 1);

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 9) < 8) op = legal_ops[$urandom_range(0, 9)];
            else                          op = 6'($urandom);
            run_instr("rand", op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 17)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
